// File: rtl/led_status_sequencer.sv
// Status LED sequencer: stretches link/activity/error events into hold periods
// and resolves them by fixed priority into one on / slow_flash / fast_flash request.
module led_status_sequencer #(
    parameter int unsigned ACT_HOLD = 1_250_000,
    parameter int unsigned ERR_HOLD = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       link,
    input  logic       activity,
    input  logic       error,
    input  logic       force_on,
    input  logic       clear_count,
    output logic       on,
    output logic       slow_flash,
    output logic       fast_flash,
    output logic [1:0] mode,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_ON   = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    localparam logic [27:0] ACT_LOAD = 28'(ACT_HOLD);
    localparam logic [27:0] ERR_LOAD = 28'(ERR_HOLD);

    logic        r_link_q;
    logic        r_link_d;
    logic        r_force_q;
    logic [27:0] r_act_cnt;
    logic [27:0] r_err_cnt;
    logic [7:0]  r_err_count;

    logic        w_link_drop;
    logic        w_err_event;
    mode_e       w_mode;

    // A link drop is seen one edge after link_q falls; link_d resets low so
    // reset release never fakes a drop.
    assign w_link_drop = r_link_d & ~r_link_q;
    assign w_err_event = error | w_link_drop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_link_q  <= 1'b0;
            r_link_d  <= 1'b0;
            r_force_q <= 1'b0;
        end else begin
            r_link_q  <= link;
            r_link_d  <= r_link_q;
            r_force_q <= force_on;
        end
    end

    // Hold counters reload on each event and only decrement while nonzero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_act_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (activity)
                r_act_cnt <= ACT_LOAD;
            else if (r_act_cnt != '0)
                r_act_cnt <= r_act_cnt - 28'd1;

            if (w_err_event)
                r_err_cnt <= ERR_LOAD;
            else if (r_err_cnt != '0)
                r_err_cnt <= r_err_cnt - 28'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (clear_count) begin
            r_err_count <= w_err_event ? 8'd1 : 8'd0;
        end else if (w_err_event && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_mode = MODE_OFF;
        if (r_force_q)
            w_mode = MODE_ON;
        else if (r_err_cnt != '0)
            w_mode = MODE_FAST;
        else if (r_act_cnt != '0)
            w_mode = MODE_ON;
        else if (r_link_q)
            w_mode = MODE_SLOW;
    end

    assign on         = (w_mode == MODE_ON);
    assign slow_flash = (w_mode == MODE_SLOW);
    assign fast_flash = (w_mode == MODE_FAST);
    assign mode       = w_mode;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench for led_status_sequencer: directed steps push hand-computed
// expectations; a monitor pops and compares one per clock after the edge.
module tb_led_status_sequencer;

    localparam int ACT_HOLD = 4;
    localparam int ERR_HOLD = 10;

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_SLOW = 2'd1;
    localparam logic [1:0] M_ON   = 2'd2;
    localparam logic [1:0] M_FAST = 2'd3;

    logic       clock;
    logic       reset_n;
    logic       link;
    logic       activity;
    logic       error;
    logic       force_on;
    logic       clear_count;
    logic       on;
    logic       slow_flash;
    logic       fast_flash;
    logic [1:0] mode;
    logic [7:0] err_count;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    led_status_sequencer #(
        .ACT_HOLD(ACT_HOLD),
        .ERR_HOLD(ERR_HOLD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .link       (link),
        .activity   (activity),
        .error      (error),
        .force_on   (force_on),
        .clear_count(clear_count),
        .on         (on),
        .slow_flash (slow_flash),
        .fast_flash (fast_flash),
        .mode       (mode),
        .err_count  (err_count)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    function automatic logic [12:0] pack(input logic [1:0] m, input logic [7:0] c);
        return {m, m == M_ON, m == M_SLOW, m == M_FAST, c};
    endfunction

    function automatic logic [12:0] observed();
        return {mode, on, slow_flash, fast_flash, err_count};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d on/slow/fast=%b%b%b cnt=%0d, required mode=%0d on/slow/fast=%b%b%b cnt=%0d",
                     name, act[12:11], act[10], act[9], act[8], act[7:0],
                     req[12:11], req[10], req[9], req[8], req[7:0]);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string name, input bit l, input bit a, input bit e,
                        input bit f, input bit c, input logic [1:0] m, input logic [7:0] cnt);
        exp_t x;
        @(negedge clock);
        link        = l;
        activity    = a;
        error       = e;
        force_on    = f;
        clear_count = c;
        x.name = name;
        x.exp  = pack(m, cnt);
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        @(negedge clock);
        link = 1'b0; activity = 1'b0; error = 1'b0; force_on = 1'b0; clear_count = 1'b0;
        while (exp_q.size() != 0 && budget < 5) begin
            @(posedge clock);
            #2;
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check(x.name, observed(), x.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        link = 1'b1; activity = 1'b1; error = 1'b1; force_on = 1'b0; clear_count = 1'b0;
        #110;
        check("reset_state", observed(), pack(M_OFF, 8'd0));
        link = 1'b0; activity = 1'b0; error = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        step("idle",      0, 0, 0, 0, 0, M_OFF,  8'd0);
        step("link_up",   1, 0, 0, 0, 0, M_SLOW, 8'd0);
        step("link_hold", 1, 0, 0, 0, 0, M_SLOW, 8'd0);

        step("act", 1, 1, 0, 0, 0, M_ON, 8'd0);
        repeat (ACT_HOLD - 1) step("act_hold", 1, 0, 0, 0, 0, M_ON, 8'd0);
        step("act_end", 1, 0, 0, 0, 0, M_SLOW, 8'd0);

        step("act_a", 1, 1, 0, 0, 0, M_ON, 8'd0);
        repeat (2) step("act_a_hold", 1, 0, 0, 0, 0, M_ON, 8'd0);
        step("act_retrig", 1, 1, 0, 0, 0, M_ON, 8'd0);
        repeat (ACT_HOLD - 1) step("act_retrig_hold", 1, 0, 0, 0, 0, M_ON, 8'd0);
        step("act_retrig_end", 1, 0, 0, 0, 0, M_SLOW, 8'd0);

        step("err_act", 1, 1, 1, 0, 0, M_FAST, 8'd1);
        repeat (ERR_HOLD - 1) step("err_hold", 1, 0, 0, 0, 0, M_FAST, 8'd1);
        step("err_end",  1, 0, 0, 0, 0, M_SLOW, 8'd1);
        step("err_end2", 1, 0, 0, 0, 0, M_SLOW, 8'd1);

        step("link_fall", 0, 0, 0, 0, 0, M_OFF,  8'd1);
        step("link_drop", 0, 0, 0, 0, 0, M_FAST, 8'd2);
        repeat (ERR_HOLD - 1) step("drop_hold", 0, 0, 0, 0, 0, M_FAST, 8'd2);
        step("drop_end", 0, 0, 0, 0, 0, M_OFF, 8'd2);

        step("force_err", 0, 0, 1, 1, 0, M_ON, 8'd3);
        repeat (3) step("force_hold", 0, 0, 0, 1, 0, M_ON, 8'd3);
        repeat (6) step("force_rel", 0, 0, 0, 0, 0, M_FAST, 8'd3);
        step("force_end", 0, 0, 0, 0, 0, M_OFF, 8'd3);

        for (int k = 1; k <= 300; k++) begin
            int c;
            c = (3 + k > 255) ? 255 : 3 + k;
            step("err_sat", 0, 0, 1, 0, 0, M_FAST, 8'(c));
        end
        step("clr_with_err", 0, 0, 1, 0, 1, M_FAST, 8'd1);
        step("clr_alone",    0, 0, 0, 0, 1, M_FAST, 8'd0);
        repeat (8) step("clr_hold", 0, 0, 0, 0, 0, M_FAST, 8'd0);
        step("clr_end", 0, 0, 0, 0, 0, M_OFF, 8'd0);

        step("pre_rst",      1, 0, 1, 0, 0, M_FAST, 8'd1);
        step("pre_rst_hold", 1, 0, 0, 0, 0, M_FAST, 8'd1);
        drain();
        @(posedge clock);
        #7;
        reset_n = 1'b0;
        #1;
        check("rst_async", observed(), pack(M_OFF, 8'd0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) step("post_rst_no_drop", 0, 0, 0, 0, 0, M_OFF, 8'd0);
        step("post_rst_link", 1, 0, 0, 0, 0, M_SLOW, 8'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
